// File: rtl/ysyx_24090012_axi_rd_arb.sv
// Two-master AXI4 read-channel arbiter: IFU and LSU share one io_master AR/R port.
// One transaction in flight; the grant is held from AR handshake through the rlast beat.
module ysyx_24090012_axi_rd_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [ID_W-1:0]   ifu_arid,
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  input  logic [1:0]        ifu_arburst,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [ID_W-1:0]   ifu_rid,
  output logic              ifu_rlast,
  output logic [1:0]        ifu_rresp,

  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [ID_W-1:0]   lsu_arid,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  input  logic [1:0]        lsu_arburst,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [ID_W-1:0]   lsu_rid,
  output logic              lsu_rlast,
  output logic [1:0]        lsu_rresp,

  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [ID_W-1:0]   io_master_arid,
  output logic [7:0]        io_master_arlen,
  output logic [2:0]        io_master_arsize,
  output logic [1:0]        io_master_arburst,
  input  logic              io_master_rvalid,
  output logic              io_master_rready,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic [ID_W-1:0]   io_master_rid,
  input  logic              io_master_rlast,
  input  logic [1:0]        io_master_rresp,

  output logic [1:0]        arb_state,
  output logic [7:0]        beat_cnt
);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_AR = 2'b01, ST_R = 2'b10, ST_BAD = 2'b11} state_e;
  typedef enum logic [1:0] {G_NONE = 2'b00, G_IFU = 2'b01, G_LSU = 2'b10} grant_e;

  state_e          state_q, state_d;
  grant_e          grant_q, grant_d;
  logic            last_lsu_q, last_lsu_d;
  logic [ID_W-1:0] arid_q, arid_d;
  logic [7:0]      arlen_q, arlen_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic            in_ar, in_r;
  logic            unused_txn;

  assign in_ar      = (state_q == ST_AR);
  assign in_r       = (state_q == ST_R);
  assign arb_state  = state_q;
  assign beat_cnt   = beat_cnt_q;
  // Latched request info is kept for debug visibility only; nothing downstream consumes it.
  assign unused_txn = ^{arid_q, arlen_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= G_NONE;
      last_lsu_q <= 1'b0;
      arid_q     <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_lsu_q <= last_lsu_d;
      arid_q     <= arid_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_lsu_d = last_lsu_q;
    arid_d     = arid_q;
    arlen_d    = arlen_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          state_d = ST_AR;
          // On contention, round-robin favours whoever did not win last; otherwise LSU wins.
          if (ifu_arvalid && lsu_arvalid) grant_d = (RR_EN && last_lsu_q) ? G_IFU : G_LSU;
          else                            grant_d = ifu_arvalid ? G_IFU : G_LSU;
        end
      end
      ST_AR: begin
        if (io_master_arvalid && io_master_arready) begin
          state_d    = ST_R;
          last_lsu_d = (grant_q == G_LSU);
          arid_d     = io_master_arid;
          arlen_d    = io_master_arlen;
          beat_cnt_d = '0;
        end
      end
      ST_R: begin
        if (io_master_rvalid && io_master_rready) begin
          if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
          if (io_master_rlast) begin
            state_d = ST_IDLE;
            grant_d = G_NONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = G_NONE;
      end
    endcase
  end

  // Channel mux: everything is steered purely by the grant register, zero when nobody holds it.
  always_comb begin
    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arid    = '0;
    io_master_arlen   = '0;
    io_master_arsize  = '0;
    io_master_arburst = '0;
    io_master_rready  = 1'b0;
    ifu_arready       = 1'b0;
    ifu_rvalid        = 1'b0;
    ifu_rdata         = '0;
    ifu_rid           = '0;
    ifu_rlast         = 1'b0;
    ifu_rresp         = '0;
    lsu_arready       = 1'b0;
    lsu_rvalid        = 1'b0;
    lsu_rdata         = '0;
    lsu_rid           = '0;
    lsu_rlast         = 1'b0;
    lsu_rresp         = '0;
    if (grant_q == G_IFU) begin
      io_master_arvalid = in_ar & ifu_arvalid;
      io_master_araddr  = ifu_araddr;
      io_master_arid    = ifu_arid;
      io_master_arlen   = ifu_arlen;
      io_master_arsize  = ifu_arsize;
      io_master_arburst = ifu_arburst;
      ifu_arready       = in_ar & io_master_arready;
      io_master_rready  = in_r & ifu_rready;
      ifu_rvalid        = in_r & io_master_rvalid;
      ifu_rdata         = io_master_rdata;
      ifu_rid           = io_master_rid;
      ifu_rlast         = io_master_rlast;
      ifu_rresp         = io_master_rresp;
    end else if (grant_q == G_LSU) begin
      io_master_arvalid = in_ar & lsu_arvalid;
      io_master_araddr  = lsu_araddr;
      io_master_arid    = lsu_arid;
      io_master_arlen   = lsu_arlen;
      io_master_arsize  = lsu_arsize;
      io_master_arburst = lsu_arburst;
      lsu_arready       = in_ar & io_master_arready;
      io_master_rready  = in_r & lsu_rready;
      lsu_rvalid        = in_r & io_master_rvalid;
      lsu_rdata         = io_master_rdata;
      lsu_rid           = io_master_rid;
      lsu_rlast         = io_master_rlast;
      lsu_rresp         = io_master_rresp;
    end
  end

endmodule

// File: tb/tb_ysyx_24090012_axi_rd_arb.sv
// Bench for ysyx_24090012_axi_rd_arb: instance 0 runs round-robin, instance 1 fixed priority;
// a slave model answers on the selected instance and a per-master scoreboard checks every R beat.
module tb_ysyx_24090012_axi_rd_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam byte CI = "I";
  localparam byte CL = "L";
  localparam byte CN = "-";

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          ifu_arvalid [2], ifu_arready [2], ifu_rvalid [2], ifu_rready [2], ifu_rlast [2];
  logic [AW-1:0] ifu_araddr [2];
  logic [IW-1:0] ifu_arid [2], ifu_rid [2];
  logic [7:0]    ifu_arlen [2];
  logic [2:0]    ifu_arsize [2];
  logic [1:0]    ifu_arburst [2], ifu_rresp [2];
  logic [DW-1:0] ifu_rdata [2];
  logic          lsu_arvalid [2], lsu_arready [2], lsu_rvalid [2], lsu_rready [2], lsu_rlast [2];
  logic [AW-1:0] lsu_araddr [2];
  logic [IW-1:0] lsu_arid [2], lsu_rid [2];
  logic [7:0]    lsu_arlen [2];
  logic [2:0]    lsu_arsize [2];
  logic [1:0]    lsu_arburst [2], lsu_rresp [2];
  logic [DW-1:0] lsu_rdata [2];
  logic          m_arvalid [2], m_arready [2], m_rvalid [2], m_rready [2], m_rlast [2];
  logic [AW-1:0] m_araddr [2];
  logic [IW-1:0] m_arid [2], m_rid [2];
  logic [7:0]    m_arlen [2];
  logic [2:0]    m_arsize [2];
  logic [1:0]    m_arburst [2], m_rresp [2];
  logic [DW-1:0] m_rdata [2];
  logic [1:0]    arb_state [2];
  logic [7:0]    beat_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ysyx_24090012_axi_rd_arb #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .RR_EN(g == 0 ? 1'b1 : 1'b0)) u_dut (
      .clock(clk), .reset(reset),
      .ifu_arvalid(ifu_arvalid[g]), .ifu_arready(ifu_arready[g]), .ifu_araddr(ifu_araddr[g]),
      .ifu_arid(ifu_arid[g]), .ifu_arlen(ifu_arlen[g]), .ifu_arsize(ifu_arsize[g]),
      .ifu_arburst(ifu_arburst[g]), .ifu_rvalid(ifu_rvalid[g]), .ifu_rready(ifu_rready[g]),
      .ifu_rdata(ifu_rdata[g]), .ifu_rid(ifu_rid[g]), .ifu_rlast(ifu_rlast[g]), .ifu_rresp(ifu_rresp[g]),
      .lsu_arvalid(lsu_arvalid[g]), .lsu_arready(lsu_arready[g]), .lsu_araddr(lsu_araddr[g]),
      .lsu_arid(lsu_arid[g]), .lsu_arlen(lsu_arlen[g]), .lsu_arsize(lsu_arsize[g]),
      .lsu_arburst(lsu_arburst[g]), .lsu_rvalid(lsu_rvalid[g]), .lsu_rready(lsu_rready[g]),
      .lsu_rdata(lsu_rdata[g]), .lsu_rid(lsu_rid[g]), .lsu_rlast(lsu_rlast[g]), .lsu_rresp(lsu_rresp[g]),
      .io_master_arvalid(m_arvalid[g]), .io_master_arready(m_arready[g]), .io_master_araddr(m_araddr[g]),
      .io_master_arid(m_arid[g]), .io_master_arlen(m_arlen[g]), .io_master_arsize(m_arsize[g]),
      .io_master_arburst(m_arburst[g]), .io_master_rvalid(m_rvalid[g]), .io_master_rready(m_rready[g]),
      .io_master_rdata(m_rdata[g]), .io_master_rid(m_rid[g]), .io_master_rlast(m_rlast[g]),
      .io_master_rresp(m_rresp[g]), .arb_state(arb_state[g]), .beat_cnt(beat_cnt[g])
    );
  end

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    int  sel;
    bit  ifu;
    bit  lsu;
    byte first;
    byte second;
  } vec_t;

  int    cur = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  beat_t q_ifu[$];
  beat_t q_lsu[$];
  byte   ar_log[$];
  int    gap_log[$];
  int    last_rlast_cyc = -100;
  logic  prev_arv = 1'b0;
  int    lsu_rv_cnt = 0;
  int    lsu_ar_during_ifu = 0;
  logic  slv_busy = 1'b0;
  int    slv_beat = 0;
  int    slv_n = 0;
  int    slv_early = 0;
  bit    slv_toggle = 1'b0;
  logic [31:0] slv_addr = '0;
  logic [3:0]  slv_id = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Presenting a request is the stimulus; the beats the slave will return for it are queued here.
  task automatic issue(input int m, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] id, input int nb);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.data = addr + 32'(4 * i);
      b.id   = id + 4'(i);
      b.resp = 2'(i);
      b.last = (i == nb - 1);
      if (m == 0) q_ifu.push_back(b); else q_lsu.push_back(b);
    end
    if (m == 0) begin
      ifu_araddr[cur] = addr; ifu_arlen[cur] = len; ifu_arid[cur] = id; ifu_arvalid[cur] = 1'b1;
    end else begin
      lsu_araddr[cur] = addr; lsu_arlen[cur] = len; lsu_arid[cur] = id; lsu_arvalid[cur] = 1'b1;
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
      done = (q_ifu.size() == 0) && (q_lsu.size() == 0) && (arb_state[cur] == 2'd0) &&
             !ifu_arvalid[cur] && !lsu_arvalid[cur] && !slv_busy;
    end
    chk({nm, "_done"}, done, 1'b1);
  endtask

  always @(posedge clk) begin : drv_p
    logic ih, lh;
    ih = ifu_arvalid[cur] && ifu_arready[cur];
    lh = lsu_arvalid[cur] && lsu_arready[cur];
    #1;
    if (ih || !reset) ifu_arvalid[cur] = 1'b0;
    if (lh || !reset) lsu_arvalid[cur] = 1'b0;
  end

  // Slave: rdata = araddr + 4*beat, rid = arid + beat (deliberately not matching), rresp = beat[1:0].
  always @(posedge clk) begin : slv_p
    logic ah, rh, rl;
    logic [31:0] a;
    logic [3:0] id;
    logic [7:0] ln;
    int s;
    s  = cur;
    ah = m_arvalid[s] && m_arready[s];
    rh = m_rvalid[s] && m_rready[s];
    rl = m_rlast[s];
    a  = m_araddr[s];
    id = m_arid[s];
    ln = m_arlen[s];
    #1;
    if (!reset) slv_busy = 1'b0;
    else begin
      if (rh && rl) slv_busy = 1'b0;
      else if (rh) slv_beat++;
      if (ah) begin
        slv_busy = 1'b1; slv_beat = 0; slv_addr = a; slv_id = id;
        slv_n = (slv_early > 0) ? slv_early : int'(ln) + 1;
      end
    end
    if (slv_busy) begin
      m_rvalid[s] = slv_toggle ? ~m_rvalid[s] : 1'b1;
      m_rdata[s]  = slv_addr + 32'(4 * slv_beat);
      m_rid[s]    = slv_id + 4'(slv_beat);
      m_rresp[s]  = 2'(slv_beat);
      m_rlast[s]  = (slv_beat == slv_n - 1);
    end else begin
      m_rvalid[s] = 1'b0; m_rdata[s] = '0; m_rid[s] = '0; m_rresp[s] = '0; m_rlast[s] = 1'b0;
    end
    m_arready[s] = 1'b1;
  end

  always @(negedge clk) begin : mon_p
    int s;
    beat_t e;
    s = cur;
    cyc++;
    if (reset) begin
      if (lsu_arready[s] && q_ifu.size() > 0) lsu_ar_during_ifu++;
      if (lsu_rvalid[s]) lsu_rv_cnt++;
      if (ifu_rvalid[s] && ifu_rready[s]) begin
        chk("ifu_beat_avail", q_ifu.size() > 0, 1'b1);
        if (q_ifu.size() > 0) begin
          e = q_ifu.pop_front();
          chk("ifu_beat", {ifu_rdata[s], ifu_rid[s], ifu_rresp[s], ifu_rlast[s]}, e);
        end
        if (ifu_rlast[s]) last_rlast_cyc = cyc;
      end
      if (lsu_rvalid[s] && lsu_rready[s]) begin
        chk("lsu_beat_avail", q_lsu.size() > 0, 1'b1);
        if (q_lsu.size() > 0) begin
          e = q_lsu.pop_front();
          chk("lsu_beat", {lsu_rdata[s], lsu_rid[s], lsu_rresp[s], lsu_rlast[s]}, e);
        end
        if (lsu_rlast[s]) last_rlast_cyc = cyc;
      end
      if (m_arvalid[s] && !prev_arv) gap_log.push_back(cyc - last_rlast_cyc);
      if (m_arvalid[s] && m_arready[s])
        ar_log.push_back(ifu_arready[s] ? CI : (lsu_arready[s] ? CL : 8'h58));
    end
    prev_arv = m_arvalid[s];
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vec[9];
    int   k;
    int   rv_hi;
    vec[0] = '{0, 1'b1, 1'b1, CL, CI};
    vec[1] = '{0, 1'b1, 1'b0, CI, CN};
    vec[2] = '{0, 1'b0, 1'b1, CL, CN};
    vec[3] = '{0, 1'b1, 1'b1, CI, CL};
    vec[4] = '{0, 1'b1, 1'b1, CI, CL};
    vec[5] = '{1, 1'b1, 1'b1, CL, CI};
    vec[6] = '{1, 1'b1, 1'b1, CL, CI};
    vec[7] = '{1, 1'b1, 1'b1, CL, CI};
    vec[8] = '{1, 1'b1, 1'b0, CI, CN};
    for (int s = 0; s < 2; s++) begin
      ifu_arvalid[s] = 0; ifu_araddr[s] = '0; ifu_arid[s] = '0; ifu_arlen[s] = '0;
      ifu_arsize[s] = 3'd2; ifu_arburst[s] = 2'd1; ifu_rready[s] = 1'b1;
      lsu_arvalid[s] = 0; lsu_araddr[s] = '0; lsu_arid[s] = '0; lsu_arlen[s] = '0;
      lsu_arsize[s] = 3'd2; lsu_arburst[s] = 2'd1; lsu_rready[s] = 1'b1;
      m_arready[s] = 1'b1; m_rvalid[s] = 0; m_rdata[s] = '0; m_rid[s] = '0;
      m_rlast[s] = 0; m_rresp[s] = '0;
    end
    ifu_arvalid[0] = 1'b1;
    ifu_araddr[0]  = 32'hDEAD_BEEF;

    // Reset held: no grant, so no ready and a zero payload despite a pending request
    #1 reset = 1'b0;
    #2;
    chk("rst_state", arb_state[0], 2'd0);
    chk("rst_beat_cnt", beat_cnt[0], 8'd0);
    chk("rst_m_arvalid", m_arvalid[0], 1'b0);
    chk("rst_ifu_arready", ifu_arready[0], 1'b0);
    chk("rst_m_rready", m_rready[0], 1'b0);
    chk("rst_m_araddr", m_araddr[0], 32'h0);
    ifu_arvalid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // IFU alone, 4-beat burst
    @(posedge clk); #1;
    issue(0, 32'h3000_0010, 8'd3, 4'h2, 4);
    @(negedge clk);
    chk("A_arb_state", arb_state[0], 2'd0);
    chk("A_arb_m_arvalid", m_arvalid[0], 1'b0);
    chk("A_arb_ifu_arready", ifu_arready[0], 1'b0);
    @(negedge clk);
    chk("A_ar_state", arb_state[0], 2'd1);
    chk("A_m_arvalid", m_arvalid[0], 1'b1);
    chk("A_m_araddr", m_araddr[0], 32'h3000_0010);
    chk("A_m_arlen", m_arlen[0], 8'd3);
    chk("A_m_arid", m_arid[0], 4'h2);
    chk("A_m_arsize", m_arsize[0], 3'd2);
    chk("A_m_arburst", m_arburst[0], 2'd1);
    chk("A_ifu_arready", ifu_arready[0], 1'b1);
    wait_idle("A", 40);
    chk("A_beat_cnt", beat_cnt[0], 8'd4);
    chk("A_lsu_rvalid_cnt", lsu_rv_cnt, 0);
    chk("A_grant_log", (ar_log.size() == 1) && (ar_log[0] == CI), 1'b1);

    // Arbitration table
    for (int v = 0; v < 9; v++) begin
      cur = vec[v].sel;
      ar_log.delete();
      gap_log.delete();
      @(posedge clk); #1;
      if (vec[v].ifu) issue(0, 32'h3000_0100 + 32'(v * 64), 8'd3, 4'(v), 4);
      if (vec[v].lsu) issue(1, 32'h8000_0000 + 32'(v * 4), 8'd0, 4'(8 + v), 1);
      wait_idle($sformatf("v%0d", v), 100);
      chk($sformatf("v%0d_first", v), (ar_log.size() > 0) ? ar_log[0] : 8'h3F, vec[v].first);
      chk($sformatf("v%0d_second", v), (ar_log.size() > 1) ? ar_log[1] : CN, vec[v].second);
      if (vec[v].ifu && vec[v].lsu)
        chk($sformatf("v%0d_gap", v), (gap_log.size() > 1) ? gap_log[1] : -1, 2);
    end

    // LSU request lands in the middle of a slow IFU burst
    cur = 0;
    ar_log.delete();
    gap_log.delete();
    lsu_ar_during_ifu = 0;
    slv_toggle = 1'b1;
    @(posedge clk); #1;
    issue(0, 32'h3000_0200, 8'd3, 4'h5, 4);
    repeat (4) @(posedge clk);
    #1;
    issue(1, 32'h8000_0100, 8'd0, 4'hA, 1);
    wait_idle("B", 100);
    chk("B_lsu_arready_early", lsu_ar_during_ifu, 0);
    chk("B_first", (ar_log.size() > 0) ? ar_log[0] : 8'h3F, CI);
    chk("B_second", (ar_log.size() > 1) ? ar_log[1] : CN, CL);
    chk("B_gap", (gap_log.size() > 1) ? gap_log[1] : -1, 2);

    // Master stalls R for 3 cycles while the slave toggles rvalid
    ifu_rready[0] = 1'b0;
    @(posedge clk); #1;
    issue(0, 32'h3000_0300, 8'd3, 4'h7, 4);
    k = 0;
    while (arb_state[0] != 2'd2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("C_reach_R", arb_state[0], 2'd2);
    rv_hi = 0;
    for (int i = 0; i < 3; i++) begin
      chk("C_m_rready", m_rready[0], 1'b0);
      chk("C_beat_cnt", beat_cnt[0], 8'd0);
      rv_hi += int'(m_rvalid[0]);
      @(negedge clk);
    end
    chk("C_rvalid_toggled", (rv_hi == 1) || (rv_hi == 2), 1'b1);
    ifu_rready[0] = 1'b1;
    wait_idle("C", 60);
    chk("C_beat_cnt_end", beat_cnt[0], 8'd4);
    slv_toggle = 1'b0;

    // Slave ends after 2 beats of a 4-beat request
    slv_early = 2;
    @(posedge clk); #1;
    issue(0, 32'h3000_0400, 8'd3, 4'h9, 2);
    wait_idle("D", 40);
    chk("D_beat_cnt", beat_cnt[0], 8'd2);
    slv_early = 0;

    // Asynchronous reset during beat 2
    @(posedge clk); #1;
    issue(0, 32'h3000_0500, 8'd3, 4'h3, 4);
    k = 0;
    while (q_ifu.size() > 3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("E_beat1_done", q_ifu.size(), 3);
    @(posedge clk); #2;
    chk("E_pre_ifu_rvalid", ifu_rvalid[0], 1'b1);
    reset = 1'b0;
    #1;
    chk("E_ifu_rvalid", ifu_rvalid[0], 1'b0);
    chk("E_m_rready", m_rready[0], 1'b0);
    chk("E_state", arb_state[0], 2'd0);
    chk("E_beat_cnt", beat_cnt[0], 8'd0);
    q_ifu.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ar_log.delete();
    gap_log.delete();
    @(posedge clk); #1;
    issue(0, 32'h3000_0600, 8'd3, 4'h4, 4);
    issue(1, 32'h8000_0200, 8'd0, 4'hB, 1);
    wait_idle("E_after", 100);
    chk("E_first", (ar_log.size() > 0) ? ar_log[0] : 8'h3F, CL);
    chk("E_second", (ar_log.size() > 1) ? ar_log[1] : CN, CI);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
